// File: rtl/sseg_banner_scanner.sv
// Multiplexed seven-segment banner scanner: scans NUM_DIGITS digits and scrolls a BANNER_LEN banner.
// Optional macro SSEG_BANNER_HEAD_DP_EN lights dp on the slot currently showing banner index 0.
module sseg_banner_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int BANNER_LEN    = 8,
  parameter int REFRESH_DIV   = 50000,
  parameter int SCROLL_FRAMES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*BANNER_LEN-1:0] banner_data,
  input  logic                    scroll_en,
  output logic [3:0]              bcd_digit,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int SLW = $clog2(NUM_DIGITS);
  localparam int FCW = $clog2(SCROLL_FRAMES + 1);
  localparam int HW  = $clog2(BANNER_LEN);
  localparam int SW  = HW + 1;

  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [SLW-1:0] SLOT_LAST    = SLW'(NUM_DIGITS - 1);
  localparam logic [FCW-1:0] FRAME_LAST   = FCW'(SCROLL_FRAMES - 1);
  localparam logic [HW-1:0]  HEAD_LAST    = HW'(BANNER_LEN - 1);

  logic [RCW-1:0] refresh_cnt_reg;
  logic [SLW-1:0] slot_reg;
  logic [FCW-1:0] frame_cnt_reg;
  logic [HW-1:0]  head_reg;
  logic [3:0]     banner_reg [BANNER_LEN];
  logic [3:0]     banner_in  [BANNER_LEN];

  logic           refresh_wrap;
  logic           frame_end;
  logic [SW-1:0]  sum_w;
  logic [HW-1:0]  idx;
  logic [HW-1:0]  head_next;

  genvar gi;
  generate
    for (gi = 0; gi < BANNER_LEN; gi++) begin : g_unpack
      assign banner_in[gi] = banner_data[4*gi +: 4];
    end
  endgenerate

  assign refresh_wrap = (refresh_cnt_reg == REFRESH_LAST);
  assign frame_end    = refresh_wrap && (slot_reg == SLOT_LAST);
  assign head_next    = (head_reg == HEAD_LAST) ? '0 : head_reg + 1'b1;

  // Slot i shows banner[(head + NUM_DIGITS-1-i) mod BANNER_LEN]; the sum stays below 2*BANNER_LEN.
  always_comb begin
    sum_w = SW'(head_reg) + SW'(NUM_DIGITS - 1) - SW'(slot_reg);
    idx   = (sum_w >= SW'(BANNER_LEN)) ? HW'(sum_w - SW'(BANNER_LEN)) : HW'(sum_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      slot_reg        <= '0;
      frame_cnt_reg   <= '0;
      head_reg        <= '0;
      for (int k = 0; k < BANNER_LEN; k++) banner_reg[k] <= '0;
      anode           <= '1;
      bcd_digit       <= '0;
    end else begin
      anode     <= ~(NUM_DIGITS'(1) << slot_reg);
      bcd_digit <= banner_reg[idx];

      refresh_cnt_reg <= refresh_wrap ? '0 : refresh_cnt_reg + 1'b1;
      if (refresh_wrap)
        slot_reg <= (slot_reg == SLOT_LAST) ? '0 : slot_reg + 1'b1;

      // Load wins over a coincident scroll step.
      if (load) begin
        for (int k = 0; k < BANNER_LEN; k++) banner_reg[k] <= banner_in[k];
        head_reg      <= '0;
        frame_cnt_reg <= '0;
      end else if (!scroll_en) begin
        frame_cnt_reg <= '0;
      end else if (frame_end) begin
        if (frame_cnt_reg == FRAME_LAST) begin
          head_reg      <= head_next;
          frame_cnt_reg <= '0;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

`ifdef SSEG_BANNER_HEAD_DP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dp <= 1'b0;
    else       dp <= (idx == '0);
  end
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_banner_scanner.sv
// Scoreboard bench for sseg_banner_scanner: a time-arithmetic model predicts every cycle's outputs.
module tb_sseg_banner_scanner;

  localparam int N   = 4;
  localparam int L   = 6;
  localparam int DIV = 4;
  localparam int SF  = 2;
  localparam int FRAME = DIV * N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [4*L-1:0] banner_data = '0;
  logic           scroll_en = 1'b0;
  logic [3:0]     bcd_digit;
  logic           dp;
  logic [N-1:0]   anode;

  int checks = 0;
  int errors = 0;

  sseg_banner_scanner #(
    .NUM_DIGITS(N), .BANNER_LEN(L), .REFRESH_DIV(DIV), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .reset(rst), .load(load), .banner_data(banner_data),
    .scroll_en(scroll_en), .bcd_digit(bcd_digit), .dp(dp), .anode(anode)
  );

  always #5 clk = ~clk;

  // Model state: cycles since reset release, banner contents, head, completed frames since head moved.
  int         cyc = 0;
  logic [3:0] mban [L];
  int         mhead = 0;
  int         mframes = 0;
  logic [8:0] expq [$];

  initial begin
    for (int k = 0; k < L; k++) mban[k] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        expq.push_back({4'b1111, 4'h0, 1'b0});
        cyc = 0; mhead = 0; mframes = 0;
        for (int k = 0; k < L; k++) mban[k] = '0;
      end else begin
        int s, ix;
        logic [3:0] an;
        logic       edp;
        s  = (cyc / DIV) % N;
        ix = (mhead + N - 1 - s) % L;
        an = 4'b1111 ^ (4'b0001 << s);
`ifdef SSEG_BANNER_HEAD_DP_EN
        edp = (ix == 0);
`else
        edp = 1'b0;
`endif
        expq.push_back({an, mban[ix], edp});
        if (load) begin
          for (int k = 0; k < L; k++) mban[k] = banner_data[4*k +: 4];
          mhead = 0; mframes = 0;
        end else if (!scroll_en) begin
          mframes = 0;
        end else if ((cyc % FRAME) == FRAME - 1) begin
          mframes++;
          if (mframes == SF) begin
            mhead = (mhead + 1) % L;
            mframes = 0;
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty actual=empty required=entry t=%0t", $time);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        if (anode !== e[8:5]) begin
          errors++;
          $display("FAIL anode actual=%b required=%b t=%0t", anode, e[8:5], $time);
        end
        checks++;
        if (bcd_digit !== e[4:1]) begin
          errors++;
          $display("FAIL bcd_digit actual=%h required=%h t=%0t", bcd_digit, e[4:1], $time);
        end
        checks++;
        if (dp !== e[0]) begin
          errors++;
          $display("FAIL dp actual=%b required=%b t=%0t", dp, e[0], $time);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [4*L-1:0] d);
    banner_data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (anode !== 4'b1111 || bcd_digit !== 4'h0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL %s actual=%b/%h/%b required=1111/0/0", tag, anode, bcd_digit, dp);
    end
  endtask

  localparam logic [4*L-1:0] SEQ123456 = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    bit found;
    run(3);
    #1 check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    run(20);

    pulse_load(SEQ123456);
    run(40);
    scroll_en = 1'b1;
    run(32 * 7);

    // Load on the exact cycle a scroll step would fire.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mframes == SF - 1 && (cyc % FRAME) == FRAME - 1) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL step_search actual=not_found required=found");
    end else begin
      pulse_load(SEQ123456);
    end
    run(70);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        banner_data = 24'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) scroll_en = ~scroll_en;
      @(negedge clk);
    end
    load = 1'b0;
    scroll_en = 1'b1;
    run(23);

    // Asynchronous reset in the middle of a slot.
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_mid_slot");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      load = ($urandom_range(0, 24) == 0);
      if (load) banner_data = 24'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    run(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
